// File: rtl/fifo_base_addr_seq.sv
// GLB base-address sequencer for the ifmap/ipsum/opsum FIFO arrays: one entry per cycle, add-only.
// Optional feature macro: ADDR_OVF_CHK_EN adds a sticky addr_ovf_o address-overflow flag.
`ifndef POINTWISE
`define POINTWISE 2'd0
`endif
`ifndef DEPTHWISE
`define DEPTHWISE 2'd1
`endif

module fifo_base_addr_seq #(
    parameter int NUM_FIFO = 32,
    parameter int ADDR_W   = 32,
    parameter int DW_ROWS  = 3,
    parameter int CNT_W    = $clog2(NUM_FIFO + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        layer_type_i,
    input  logic [CNT_W-1:0]  num_ch_i,
    input  logic              is_bias_i,
    input  logic [ADDR_W-1:0] ifmap_glb_base_addr_i,
    input  logic [ADDR_W-1:0] ipsum_glb_base_addr_i,
    input  logic [ADDR_W-1:0] opsum_glb_base_addr_i,
    input  logic [ADDR_W-1:0] bias_glb_base_addr_i,
    input  logic [31:0]       tile_n_i,
    input  logic [31:0]       On_real_i,
    input  logic [7:0]        in_C_i,
    input  logic [1:0]        pad_L_i,
    input  logic [1:0]        pad_R_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
`ifdef ADDR_OVF_CHK_EN
    output logic              addr_ovf_o,
`endif
    output logic              ifmap_fifo_reset_o,
    output logic              ipsum_fifo_reset_o,
    output logic              opsum_fifo_reset_o,
    output logic [ADDR_W-1:0] ifmap_fifo_base_addr_o [NUM_FIFO],
    output logic [ADDR_W-1:0] ipsum_fifo_base_addr_o [NUM_FIFO],
    output logic [ADDR_W-1:0] opsum_fifo_base_addr_o [NUM_FIFO]
);

    localparam int DW_CH = NUM_FIFO / DW_ROWS;

    typedef enum logic [1:0] {IDLE, SETUP, CALC, DONE} state_t;

    state_t state_r, state_nx;

    // Latched configuration
    logic [1:0]        layer_r;
    logic [CNT_W-1:0]  num_ch_r;
    logic              is_bias_r;
    logic [ADDR_W-1:0] if_base_r, ip_base_r, op_base_r, bias_base_r;
    logic [31:0]       tile_n_r, on_real_r;
    logic [7:0]        in_c_r;
    logic [1:0]        pad_l_r, pad_r_r;

    // Strides, counters and accumulators
    logic [ADDR_W-1:0] if_str_r, ip_str_r, op_str_r;
    logic [ADDR_W-1:0] if_row_r, ip_row_r, op_row_r;
    logic [ADDR_W-1:0] if_ch_r, ip_ch_r, op_ch_r;
    logic [ADDR_W-1:0] if_rw_r, ip_rw_r, op_rw_r;
    logic [CNT_W-1:0]  k_r, r_r, active_r;
    logic              busy_r;

    logic              is_pw_s, is_dw_s, valid_s, entry_en_s, row_wrap_s;
    logic [9:0]        row_w_s;
    logic [ADDR_W-1:0] if_prod_s, ip_prod_s, op_prod_s;
    logic [CNT_W-1:0]  pw_active_s, dw_ch_s, dw_active_s;
    logic [ADDR_W-1:0] if_val_s, ip_val_s, op_val_s;

    assign is_pw_s    = (layer_r == `POINTWISE);
    assign is_dw_s    = (layer_r == `DEPTHWISE);
    assign valid_s    = is_pw_s || is_dw_s;
    assign row_w_s    = 10'(in_c_r) + 10'(pad_l_r) + 10'(pad_r_r);
    assign if_prod_s  = ADDR_W'(tile_n_r) * ADDR_W'(row_w_s);
    assign ip_prod_s  = ADDR_W'(tile_n_r) * ADDR_W'(in_c_r);
    assign op_prod_s  = ADDR_W'(on_real_r) * ADDR_W'(in_c_r);

    assign pw_active_s = (num_ch_r > CNT_W'(NUM_FIFO)) ? CNT_W'(NUM_FIFO) : num_ch_r;
    assign dw_ch_s     = (num_ch_r > CNT_W'(DW_CH)) ? CNT_W'(DW_CH) : num_ch_r;
    assign dw_active_s = dw_ch_s * CNT_W'(DW_ROWS);

    assign entry_en_s = valid_s && (k_r < active_r);
    assign row_wrap_s = (r_r == CNT_W'(DW_ROWS - 1));
    assign if_val_s   = entry_en_s ? (if_ch_r + if_rw_r) : {ADDR_W{1'b0}};
    assign ip_val_s   = entry_en_s ? (ip_ch_r + ip_rw_r) : {ADDR_W{1'b0}};
    assign op_val_s   = entry_en_s ? (op_ch_r + op_rw_r) : {ADDR_W{1'b0}};

    assign busy_o             = busy_r;
    assign ifmap_fifo_reset_o = busy_r;
    assign ipsum_fifo_reset_o = busy_r;
    assign opsum_fifo_reset_o = busy_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; CALC lasts exactly NUM_FIFO cycles
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) state_nx = SETUP;
                else         state_nx = IDLE;
            end
            SETUP: state_nx = CALC;
            CALC: begin
                if (k_r == CNT_W'(NUM_FIFO - 1)) state_nx = DONE;
                else                             state_nx = CALC;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs; done lands NUM_FIFO+2 cycles after the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_o    <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            busy_r    <= (state_nx == SETUP) || (state_nx == CALC);
            done_o    <= (state_r == DONE);
            cfg_err_o <= (state_r == DONE) && !valid_s;
        end
    end

    // Configuration capture on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_r     <= 2'd0;
            num_ch_r    <= '0;
            is_bias_r   <= 1'b0;
            if_base_r   <= '0;
            ip_base_r   <= '0;
            op_base_r   <= '0;
            bias_base_r <= '0;
            tile_n_r    <= 32'd0;
            on_real_r   <= 32'd0;
            in_c_r      <= 8'd0;
            pad_l_r     <= 2'd0;
            pad_r_r     <= 2'd0;
        end else if (state_r == IDLE && start_i) begin
            layer_r     <= layer_type_i;
            num_ch_r    <= num_ch_i;
            is_bias_r   <= is_bias_i;
            if_base_r   <= ifmap_glb_base_addr_i;
            ip_base_r   <= ipsum_glb_base_addr_i;
            op_base_r   <= opsum_glb_base_addr_i;
            bias_base_r <= bias_glb_base_addr_i;
            tile_n_r    <= tile_n_i;
            on_real_r   <= On_real_i;
            in_c_r      <= in_C_i;
            pad_l_r     <= pad_L_i;
            pad_r_r     <= pad_R_i;
        end
    end

    // Stride setup and add-only accumulation; channel accumulators start at the array base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_str_r <= '0; ip_str_r <= '0; op_str_r <= '0;
            if_row_r <= '0; ip_row_r <= '0; op_row_r <= '0;
            if_ch_r  <= '0; ip_ch_r  <= '0; op_ch_r  <= '0;
            if_rw_r  <= '0; ip_rw_r  <= '0; op_rw_r  <= '0;
            k_r      <= '0;
            r_r      <= '0;
            active_r <= '0;
        end else if (state_r == SETUP) begin
            if (is_dw_s) begin
                if_str_r <= if_prod_s;
                ip_str_r <= ip_prod_s;
                op_str_r <= op_prod_s;
                if_row_r <= ADDR_W'(row_w_s);
                ip_row_r <= ADDR_W'(in_c_r);
                op_row_r <= ADDR_W'(in_c_r);
                active_r <= dw_active_s;
            end else begin
                if_str_r <= ADDR_W'(tile_n_r);
                ip_str_r <= ADDR_W'(tile_n_r);
                op_str_r <= ADDR_W'(on_real_r);
                if_row_r <= '0;
                ip_row_r <= '0;
                op_row_r <= '0;
                active_r <= pw_active_s;
            end
            if_ch_r <= if_base_r;
            ip_ch_r <= is_bias_r ? bias_base_r : ip_base_r;
            op_ch_r <= op_base_r;
            if_rw_r <= '0; ip_rw_r <= '0; op_rw_r <= '0;
            k_r     <= '0;
            r_r     <= '0;
        end else if (state_r == CALC) begin
            k_r <= k_r + CNT_W'(1);
            if (is_dw_s && !row_wrap_s) begin
                r_r     <= r_r + CNT_W'(1);
                if_rw_r <= if_rw_r + if_row_r;
                ip_rw_r <= ip_rw_r + ip_row_r;
                op_rw_r <= op_rw_r + op_row_r;
            end else begin
                r_r     <= '0;
                if_rw_r <= '0; ip_rw_r <= '0; op_rw_r <= '0;
                if_ch_r <= if_ch_r + if_str_r;
                ip_ch_r <= ip_ch_r + ip_str_r;
                op_ch_r <= op_ch_r + op_str_r;
            end
        end
    end

    // Address arrays: entry k of each array is rewritten once per CALC pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FIFO; i++) begin
                ifmap_fifo_base_addr_o[i] <= '0;
                ipsum_fifo_base_addr_o[i] <= '0;
                opsum_fifo_base_addr_o[i] <= '0;
            end
        end else if (state_r == CALC) begin
            for (int i = 0; i < NUM_FIFO; i++) begin
                if (k_r == CNT_W'(i)) begin
                    ifmap_fifo_base_addr_o[i] <= if_val_s;
                    ipsum_fifo_base_addr_o[i] <= ip_val_s;
                    opsum_fifo_base_addr_o[i] <= op_val_s;
                end
            end
        end
    end

`ifdef ADDR_OVF_CHK_EN
    function automatic logic add_cy(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ADDR_W];
    endfunction

    function automatic logic prod_cy(input logic [41:0] p);
        return |(p >> ADDR_W);
    endfunction

    logic [41:0] if_wide_s, ip_wide_s, op_wide_s;
    logic        sum_cy_s, ch_cy_s, rw_cy_s;
    logic        ch_wrap_r, rw_wrap_r, ovf_r;

    assign if_wide_s  = 42'(tile_n_r) * 42'(row_w_s);
    assign ip_wide_s  = 42'(tile_n_r) * 42'(in_c_r);
    assign op_wide_s  = 42'(on_real_r) * 42'(in_c_r);
    assign sum_cy_s   = add_cy(if_ch_r, if_rw_r) | add_cy(ip_ch_r, ip_rw_r) | add_cy(op_ch_r, op_rw_r);
    assign ch_cy_s    = add_cy(if_ch_r, if_str_r) | add_cy(ip_ch_r, ip_str_r) | add_cy(op_ch_r, op_str_r);
    assign rw_cy_s    = add_cy(if_rw_r, if_row_r) | add_cy(ip_rw_r, ip_row_r) | add_cy(op_rw_r, op_row_r);
    assign addr_ovf_o = ovf_r;

    // Wrap bits ride along with the accumulators and only count when an active entry uses them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_wrap_r <= 1'b0;
            rw_wrap_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (state_r == SETUP) begin
            ovf_r     <= 1'b0;
            rw_wrap_r <= 1'b0;
            ch_wrap_r <= is_dw_s && (prod_cy(if_wide_s) | prod_cy(ip_wide_s) | prod_cy(op_wide_s));
        end else if (state_r == CALC) begin
            if (entry_en_s) ovf_r <= ovf_r | ch_wrap_r | rw_wrap_r | sum_cy_s;
            else            ovf_r <= ovf_r;
            if (is_dw_s && !row_wrap_s) begin
                rw_wrap_r <= rw_wrap_r | rw_cy_s;
            end else begin
                rw_wrap_r <= 1'b0;
                ch_wrap_r <= ch_wrap_r | ch_cy_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_base_addr_seq.sv
// Self-checking bench for fifo_base_addr_seq: table vectors, corner sequences, randomized runs vs. a formula model.
`ifndef POINTWISE
`define POINTWISE 2'd0
`endif
`ifndef DEPTHWISE
`define DEPTHWISE 2'd1
`endif

module tb_fifo_base_addr_seq;
    localparam int NF  = 32;
    localparam int DWR = 3;
    localparam int CW  = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  layer;
    logic [CW-1:0] nch;
    logic        bias;
    logic [31:0] if_base, ip_base, op_base, b_base, tile, onr;
    logic [7:0]  inc;
    logic [1:0]  pl, pr;
    logic        busy, done, cfg_err, ifr, ipr, opr;
    logic [31:0] if_arr [NF];
    logic [31:0] ip_arr [NF];
    logic [31:0] op_arr [NF];
`ifdef ADDR_OVF_CHK_EN
    logic        addr_ovf;
`endif

    always #5 clk = ~clk;

    fifo_base_addr_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .layer_type_i(layer), .num_ch_i(nch),
        .is_bias_i(bias), .ifmap_glb_base_addr_i(if_base), .ipsum_glb_base_addr_i(ip_base),
        .opsum_glb_base_addr_i(op_base), .bias_glb_base_addr_i(b_base), .tile_n_i(tile),
        .On_real_i(onr), .in_C_i(inc), .pad_L_i(pl), .pad_R_i(pr),
        .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
`ifdef ADDR_OVF_CHK_EN
        .addr_ovf_o(addr_ovf),
`endif
        .ifmap_fifo_reset_o(ifr), .ipsum_fifo_reset_o(ipr), .opsum_fifo_reset_o(opr),
        .ifmap_fifo_base_addr_o(if_arr), .ipsum_fifo_base_addr_o(ip_arr), .opsum_fifo_base_addr_o(op_arr)
    );

    typedef struct {
        logic [1:0] layer; logic [CW-1:0] nch; logic bias;
        logic [31:0] if_base, ip_base, op_base, b_base, tile, onr;
        logic [7:0] inc; logic [1:0] pl, pr;
    } cfg_t;

    typedef struct {
        cfg_t c; int idx; logic [31:0] e_if, e_ip, e_op; logic e_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int r_lat, r_busy, r_done, r_stray, r_rstmis;
    logic r_err;

    function automatic cfg_t mk(input logic [1:0] ly, input logic [CW-1:0] n, input logic b,
                                input logic [31:0] ifb, input logic [31:0] ipb, input logic [31:0] opb,
                                input logic [31:0] bb, input logic [31:0] t, input logic [31:0] o,
                                input logic [7:0] ic, input logic [1:0] l, input logic [1:0] r);
        cfg_t c;
        c.layer = ly; c.nch = n; c.bias = b; c.if_base = ifb; c.ip_base = ipb; c.op_base = opb;
        c.b_base = bb; c.tile = t; c.onr = o; c.inc = ic; c.pl = l; c.pr = r;
        return c;
    endfunction

    // Expected entry i of array a (0 ifmap, 1 ipsum, 2 opsum) from the closed-form address rule
    function automatic logic [31:0] model(input cfg_t c, input int a, input int i);
        int n, act;
        logic [31:0] base, chs, rows, row_w;
        n = int'(c.nch);
        if (c.layer != `POINTWISE && c.layer != `DEPTHWISE) return 32'h0;
        if (c.layer == `POINTWISE) act = (n > NF) ? NF : n;
        else                       act = ((n > NF / DWR) ? NF / DWR : n) * DWR;
        if (i >= act) return 32'h0;
        row_w = 32'(c.inc) + 32'(c.pl) + 32'(c.pr);
        base  = (a == 0) ? c.if_base : (a == 1) ? (c.bias ? c.b_base : c.ip_base) : c.op_base;
        if (c.layer == `POINTWISE) begin
            chs = (a == 2) ? c.onr : c.tile;
            return base + 32'(i) * chs;
        end
        chs  = (a == 0) ? c.tile * row_w : (a == 1) ? c.tile * 32'(c.inc) : c.onr * 32'(c.inc);
        rows = (a == 0) ? row_w : 32'(c.inc);
        return base + 32'(i / DWR) * chs + 32'(i % DWR) * rows;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input cfg_t c);
        layer = c.layer; nch = c.nch; bias = c.bias; if_base = c.if_base; ip_base = c.ip_base;
        op_base = c.op_base; b_base = c.b_base; tile = c.tile; onr = c.onr; inc = c.inc;
        pl = c.pl; pr = c.pr;
    endtask

    task automatic scramble();
        layer = 2'($urandom); nch = CW'($urandom); bias = 1'($urandom); if_base = $urandom;
        ip_base = $urandom; op_base = $urandom; b_base = $urandom; tile = $urandom; onr = $urandom;
        inc = 8'($urandom); pl = 2'($urandom); pr = 2'($urandom);
    endtask

    // One start, then 59 sampled cycles; inputs are scrambled after acceptance to prove latching
    task automatic run(input cfg_t c, input bit mid_start);
        @(negedge clk);
        apply(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        r_lat = -1; r_busy = 0; r_done = 0; r_stray = 0; r_rstmis = 0; r_err = 1'b0;
        for (int n = 1; n < 60; n++) begin
            if (busy) r_busy++;
            if (done) begin
                r_done++;
                if (r_lat < 0) r_lat = n - 1;
                r_err = cfg_err;
            end else if (cfg_err) begin
                r_stray++;
            end
            if (ifr !== busy || ipr !== busy || opr !== busy) r_rstmis++;
            start = (mid_start && n == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_arrays(input string name, input cfg_t c);
        int bad;
        logic [31:0] act, exp;
        for (int a = 0; a < 3; a++) begin
            bad = 0;
            for (int i = 0; i < NF; i++) begin
                act = (a == 0) ? if_arr[i] : (a == 1) ? ip_arr[i] : op_arr[i];
                exp = model(c, a, i);
                if (act !== exp) begin
                    if (bad == 0) $display("  %s arr%0d entry %0d: got 0x%08h want 0x%08h", name, a, i, act, exp);
                    bad++;
                end
            end
            check($sformatf("%s_arr%0d_bad_entries", name, a), 32'(bad), 32'd0);
        end
    endtask

    task automatic check_run(input string name, input cfg_t c);
        check({name, "_latency"}, 32'(r_lat), 32'd34);
        check({name, "_busy_cycles"}, 32'(r_busy), 32'd33);
        check({name, "_done_count"}, 32'(r_done), 32'd1);
        check({name, "_cfg_err"}, 32'(r_err), (c.layer > 2'd1) ? 32'd1 : 32'd0);
        check({name, "_stray_err"}, 32'(r_stray), 32'd0);
        check({name, "_reset_vs_busy"}, 32'(r_rstmis), 32'd0);
        check_arrays(name, c);
    endtask

    vec_t vt[13];
    cfg_t cA, cB, cC, cD, cE, cF, cG, rc;
    int cnt, nz;

    initial begin
        cA = mk(`POINTWISE, 6'd4, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'd16, 32'd0, 8'd0, 2'd0, 2'd0);
        cB = mk(`DEPTHWISE, 6'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd4, 32'd6, 8'd8, 2'd1, 2'd1);
        cC = mk(`DEPTHWISE, 6'd2, 1'b1, 32'h0, 32'h999, 32'h0, 32'h200, 32'd4, 32'd6, 8'd8, 2'd0, 2'd0);
        cD = mk(`DEPTHWISE, 6'd15, 1'b0, 32'h100, 32'h100, 32'h100, 32'h0, 32'd1, 32'd1, 8'd1, 2'd0, 2'd0);
        cE = mk(`POINTWISE, 6'd40, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd2, 32'd3, 8'd0, 2'd0, 2'd0);
        cF = mk(2'b11, 6'd4, 1'b0, 32'h1000, 32'h10, 32'h20, 32'h0, 32'd16, 32'd5, 8'd8, 2'd1, 2'd1);
        cG = mk(`POINTWISE, 6'd0, 1'b0, 32'h1000, 32'h10, 32'h20, 32'h0, 32'd16, 32'd5, 8'd8, 2'd0, 2'd0);
        vt[0]  = '{cA, 0,  32'h1000, 32'h0,   32'h0,  1'b0};
        vt[1]  = '{cA, 3,  32'h1030, 32'h30,  32'h0,  1'b0};
        vt[2]  = '{cA, 4,  32'h0,    32'h0,   32'h0,  1'b0};
        vt[3]  = '{cB, 3,  32'd40,   32'd32,  32'd48, 1'b0};
        vt[4]  = '{cB, 5,  32'd60,   32'd48,  32'd64, 1'b0};
        vt[5]  = '{cB, 6,  32'h0,    32'h0,   32'h0,  1'b0};
        vt[6]  = '{cC, 2,  32'd16,   32'h210, 32'd16, 1'b0};
        vt[7]  = '{cC, 4,  32'd40,   32'h228, 32'd56, 1'b0};
        vt[8]  = '{cD, 29, 32'h10B,  32'h10B, 32'h10B, 1'b0};
        vt[9]  = '{cD, 30, 32'h0,    32'h0,   32'h0,  1'b0};
        vt[10] = '{cE, 31, 32'd62,   32'd62,  32'd93, 1'b0};
        vt[11] = '{cF, 0,  32'h0,    32'h0,   32'h0,  1'b1};
        vt[12] = '{cG, 0,  32'h0,    32'h0,   32'h0,  1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        apply(cA);
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_cfg_err", 32'(cfg_err), 32'd0);
        check("reset_fifo_resets", 32'({ifr, ipr, opr}), 32'd0);
        nz = 0;
        for (int i = 0; i < NF; i++) if (if_arr[i] != 0 || ip_arr[i] != 0 || op_arr[i] != 0) nz++;
        check("reset_arrays_nonzero", 32'(nz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            run(vt[v].c, 1'b0);
            check_run($sformatf("vec%0d", v), vt[v].c);
            check($sformatf("vec%0d_if[%0d]", v, vt[v].idx), if_arr[vt[v].idx], vt[v].e_if);
            check($sformatf("vec%0d_ip[%0d]", v, vt[v].idx), ip_arr[vt[v].idx], vt[v].e_ip);
            check($sformatf("vec%0d_op[%0d]", v, vt[v].idx), op_arr[vt[v].idx], vt[v].e_op);
            check($sformatf("vec%0d_err", v), 32'(r_err), 32'(vt[v].e_err));
        end

        // start pulse during CALC must be ignored
        run(cB, 1'b1);
        check_run("mid_start", cB);

        // asynchronous abort mid-CALC, then a clean restart
        @(negedge clk);
        apply(cA);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fifo_resets", 32'({ifr, ipr, opr}), 32'd0);
        nz = 0;
        for (int i = 0; i < NF; i++) if (if_arr[i] != 0 || ip_arr[i] != 0 || op_arr[i] != 0) nz++;
        check("abort_arrays_nonzero", 32'(nz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (45) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("abort_no_activity", 32'(cnt), 32'd0);
        run(cC, 1'b0);
        check_run("after_abort", cC);

        // randomized configurations against the formula model
        for (int t = 0; t < 20; t++) begin
            cnt = int'($urandom_range(0, 9));
            rc = mk((cnt == 0) ? 2'd2 : (cnt == 1) ? 2'd3 : ((cnt % 2 == 0) ? `POINTWISE : `DEPTHWISE),
                    CW'($urandom_range(0, 40)), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                    (t < 10) ? 32'($urandom_range(0, 300)) : $urandom, $urandom,
                    8'($urandom), 2'($urandom), 2'($urandom));
            run(rc, 1'b0);
            check_run($sformatf("rand%0d", t), rc);
        end

`ifdef ADDR_OVF_CHK_EN
        run(cA, 1'b0);
        check("ovf_clear", 32'(addr_ovf), 32'd0);
        run(mk(`POINTWISE, 6'd2, 1'b0, 32'hFFFFFFF0, 32'h0, 32'h0, 32'h0, 32'd16, 32'd0, 8'd0, 2'd0, 2'd0), 1'b0);
        check("ovf_set", 32'(addr_ovf), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_base_addr_seq.md
Name: fifo_base_addr_seq

Overview:
Parametrised successor to the FIFO/PE init stage of the token engine. It computes the GLB base addresses for every ifmap, ipsum and opsum FIFO from the tile configuration. It uses a start/done handshake and a sequential add-only accumulator datapath, one FIFO entry per cycle. Unused entries are cleared, the FIFO resets are held for the whole init window, and unsupported layer types are flagged. It sits between Tile_Scheduler and the FIFO array.

Parameters:
NUM_FIFO, 32, FIFO entries per array (ifmap/ipsum/opsum); depthwise uses floor(NUM_FIFO/DW_ROWS) channels.
ADDR_W, 32, GLB address width; all address arithmetic is modulo 2^ADDR_W.
DW_ROWS, 3, kernel rows per channel in depthwise mode.
CNT_W, $clog2(NUM_FIFO+1), width of the entry and channel counters.

Ports:
clk  in  1  clock
rst_n  in  1  reset
start_i  in  1  start pulse; accepted only in IDLE
layer_type_i  in  2  `POINTWISE or `DEPTHWISE; any other value is an error
num_ch_i  in  CNT_W  channels in this tile
is_bias_i  in  1  1: ipsum array is based at bias_glb_base_addr_i
ifmap_glb_base_addr_i / ipsum_glb_base_addr_i / opsum_glb_base_addr_i / bias_glb_base_addr_i  in  ADDR_W each  GLB bases
tile_n_i  in  32  tile length
On_real_i  in  32  real output length
in_C_i  in  8  input width
pad_L_i, pad_R_i  in  2 each  padding
busy_o  out  1  high from SETUP through CALC
done_o  out  1  one-cycle pulse when all entries are valid
cfg_err_o  out  1  pulses with done_o on an unsupported layer_type_i
ifmap_fifo_reset_o, ipsum_fifo_reset_o, opsum_fifo_reset_o  out  1 each  equal to busy_o
ifmap_fifo_base_addr_o, ipsum_fifo_base_addr_o, opsum_fifo_base_addr_o  out  ADDR_W x NUM_FIFO  registered base addresses

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: every output is 0, FSM in IDLE.
- FSM states: IDLE -> SETUP -> CALC -> DONE -> IDLE.
- IDLE: when start_i=1, latch all configuration inputs and go to SETUP. start_i is ignored in every other state.
- SETUP (1 cycle):
  - row_w = in_C_i + pad_L_i + pad_R_i, 10-bit.
  - Pointwise: if_str = ip_str = tile_n_i; op_str = On_real_i; row strides unused.
  - Depthwise: if_str = tile_n_i*row_w; ip_str = tile_n_i*in_C_i; op_str = On_real_i*in_C_i; if_row = row_w; ip_row = op_row = in_C_i.
  - This is the only state that uses multipliers; products are truncated to ADDR_W.
  - Clear the entry counter k, channel counter c, row counter r and the accumulators.
  - active = min(num_ch_i, NUM_FIFO) for pointwise; min(num_ch_i, NUM_FIFO/DW_ROWS)*DW_ROWS for depthwise.
  - ipsum base = is_bias_i ? bias_glb_base_addr_i : ipsum_glb_base_addr_i.
- CALC (exactly NUM_FIFO cycles): write entry k of all three arrays each cycle.
  - If k < active and the layer type is valid, the value is channel accumulator + row accumulator. Otherwise it is 0.
  - Pointwise: channel accumulator += stride every cycle.
  - Depthwise: row accumulator += row stride. When r reaches DW_ROWS-1, r and the row accumulator return to 0 and the channel accumulator += channel stride.
  - No multiplier is allowed in CALC.
- DONE (1 cycle): done_o=1; cfg_err_o=1 if the layer type is invalid; busy_o=0.
- Latency: done_o is asserted NUM_FIFO+2 cycles after the accepting start_i edge.
- Array registers hold their values until the next SETUP. Entries are only rewritten in CALC.
- num_ch_i=0: every entry is 0, done_o still pulses.
- Reset during SETUP/CALC/DONE aborts immediately: outputs return to 0 and any pending done is lost.

Optional Feature:
ADDR_OVF_CHK_EN
- With the macro defined: an extra output addr_ovf_o (1 bit) is added.
- addr_ovf_o is cleared in SETUP and set sticky if any accumulator add or SETUP product for an active entry exceeds 2^ADDR_W-1.
- It is valid with done_o and held until the next SETUP.
- Without the macro: the port and logic are absent and wrap-around is silent.

Test Plan:
- Pointwise: ifmap base 0x1000, tile_n 16, num_ch 4 -> ifmap[0..3] = 0x1000, 0x1010, 0x1020, 0x1030; [4..31] = 0. done_o pulses 34 cycles after start; resets high for 32+1 cycles.
- Depthwise: ifmap base 0, in_C 8, pad 1/1, tile_n 4, num_ch 2 -> ifmap[0..5] = 0, 10, 20, 40, 50, 60; [6..31] = 0.
- Depthwise with is_bias=1: bias base 0x200, in_C 8, tile_n 4, On_real 6, num_ch 2 -> ipsum[0..5] = 0x200, 0x208, 0x210, 0x220, 0x228, 0x230; opsum[0..5] = 0, 8, 16, 48, 56, 64.
- Clamp: depthwise num_ch 15 -> entries 0..29 valid, 30 and 31 = 0. Pointwise num_ch 40 -> all 32 valid.
- layer_type 2'b11 -> all entries 0, done_o and cfg_err_o pulse together. A start_i pulse during CALC is ignored with no extra done.
- rst_n low mid-CALC -> all outputs 0 asynchronously, FSM in IDLE. A new start afterwards completes normally. With ADDR_OVF_CHK_EN: base 0xFFFFFFF0, tile_n 16, num_ch 2 -> addr_ovf_o = 1.
